// File: rtl/mirfak_if_prefetch.sv
// Prefetching instruction fetch: a Wishbone master runs ahead of decode into a DEPTH-entry FIFO; ack-to-ID latency is 2 cycles.
// Requests are issued only when a FIFO slot is guaranteed, so a stalled ID throttles the bus instead of overflowing.

module mirfak_if_prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module mirfak_if_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_except_i,
  input  logic [31:0] pc_xret_i,
  input  logic [31:0] pc_bj_i,
  input  logic        pc_except_sel_i,
  input  logic        pc_xret_sel_i,
  input  logic        pc_bj_sel_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        ifid_enable_i,
  input  logic        ifid_clear_i,
  output logic        if_ready_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_instruction_o,
  output logic        id_if_exception_o,
  output logic [3:0]  id_if_xcause_o,
  output logic        id_bubble
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  xcause;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic          req_active;
  logic          redirect;
  logic [31:0]   npc;
  logic          push;
  logic          pop;
  logic          flush;
  logic          empty;
  logic          space;
  logic          space_after;
  entry_t        push_dat;
  entry_t        head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_left;

  assign redirect = pc_except_sel_i | pc_xret_sel_i | pc_bj_sel_i;

  always_comb begin
    npc = pc_bj_i;
    if (pc_except_sel_i)    npc = pc_except_i;
    else if (pc_xret_sel_i) npc = pc_xret_i;
  end

  assign empty       = (count == '0);
  assign pop         = ifid_enable_i & ~empty & ~redirect & ~ifid_clear_i;
  assign count_left  = count - {{(CW-1){1'b0}}, pop};
  assign space       = count_left < CW'(DEPTH);
  // Occupancy after this cycle's ack lands; decides whether to keep the bus cycle open.
  assign space_after = (count_left + 1'b1) < CW'(DEPTH);
  assign flush       = redirect;

  always_comb begin
    push            = 1'b0;
    push_dat.pc     = fetch_pc;
    push_dat.instr  = NOP;
    push_dat.exc    = 1'b1;
    push_dat.xcause = 4'd0;
    if (!redirect) begin
      case (state)
        IDLE: if (fetch_pc[1:0] != 2'b00 && space) push = 1'b1;
        REQ: begin
          if (iwbm_ack_i) begin
            push           = 1'b1;
            push_dat.instr = iwbm_dat_i;
            push_dat.exc   = 1'b0;
          end else if (iwbm_err_i) begin
            push            = 1'b1;
            push_dat.xcause = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  mirfak_if_prefetch_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fetch_pc   <= RESET_ADDR;
      req_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= npc;
          end else if (fetch_pc[1:0] != 2'b00) begin
            if (space) state <= HALT;
          end else if (space) begin
            req_active <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            req_active <= 1'b0;
            fetch_pc   <= npc;
            state      <= IDLE;
          end else if (iwbm_ack_i) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (!space_after) begin
              req_active <= 1'b0;
              state      <= IDLE;
            end
          end else if (iwbm_err_i) begin
            req_active <= 1'b0;
            state      <= HALT;
          end
        end
        HALT: begin
          if (redirect) begin
            fetch_pc <= npc;
            state    <= IDLE;
          end
        end
        default: begin
          req_active <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign iwbm_addr_o = fetch_pc;
  assign iwbm_cyc_o  = req_active;
  assign iwbm_stb_o  = req_active;
  assign if_ready_o  = ~empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_pc_o           <= '0;
      id_pc4_o          <= '0;
      id_instruction_o  <= NOP;
      id_if_exception_o <= 1'b0;
      id_if_xcause_o    <= '0;
      id_bubble         <= 1'b1;
    end else if (ifid_clear_i || (redirect && ifid_enable_i) || (ifid_enable_i && empty)) begin
      id_pc_o           <= '0;
      id_pc4_o          <= '0;
      id_instruction_o  <= NOP;
      id_if_exception_o <= 1'b0;
      id_if_xcause_o    <= '0;
      id_bubble         <= 1'b1;
    end else if (pop) begin
      id_pc_o           <= head.pc;
      id_pc4_o          <= head.pc + 32'd4;
      id_instruction_o  <= head.instr;
      id_if_exception_o <= head.exc;
      id_if_xcause_o    <= head.xcause;
      id_bubble         <= 1'b0;
    end
  end
endmodule
